// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: instruction-memory, redirect and decode-side handshake bundle
interface if_fetch_queue_if #(parameter int IM_AW = 10);
    logic             im_req;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_dout;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic [31:0]      out_pc4;
    modport master (
        output im_req, im_addr, out_valid, out_inst, out_pc, out_pc4,
        input  im_dout, redirect, redirect_pc, out_ready
    );
    modport slave (
        input  im_req, im_addr, out_valid, out_inst, out_pc, out_pc4,
        output im_dout, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC owner, IM requester and PC-tagged instruction FIFO for decode
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IM_AW    = 10
) (
    input logic clk,
    input logic rst,
    if_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic {RUN, STALL} state_t;
    state_t      state, state_nx;
    logic [31:0] fetch_pc, tag_pc, tgt;
    logic        inflight, issue, credit, push, pop;
    logic [PW:0] count;
    logic [PW-1:0] rptr, wptr;
    logic [31:0] inst_q [DEPTH];
    logic [31:0] pc_q [DEPTH];
    assign tgt    = {bus.redirect_pc[31:2], 2'b00};
    // a response already in flight will need a slot next cycle
    assign credit = int'(count) + int'(inflight) < DEPTH;
    assign push   = inflight & ~bus.redirect;
    assign pop    = bus.out_valid & bus.out_ready;
    always_comb begin
        issue    = bus.redirect | (state == RUN & credit);
        state_nx = (bus.redirect | credit) ? RUN : STALL;
    end
    assign bus.im_req    = issue & ~rst;
    assign bus.im_addr   = bus.redirect ? tgt[IM_AW-1:0] : fetch_pc[IM_AW-1:0];
    assign bus.out_valid = count != '0;
    assign bus.out_inst  = inst_q[rptr];
    assign bus.out_pc    = pc_q[rptr];
    assign bus.out_pc4   = pc_q[rptr] + 32'd4;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rptr     <= '0;
            wptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state    <= state_nx;
            inflight <= issue;
            tag_pc   <= bus.redirect ? tgt : fetch_pc;
            fetch_pc <= bus.redirect ? tgt + 32'd4 : issue ? fetch_pc + 32'd4 : fetch_pc;
            if (push) begin
                inst_q[wptr] <= bus.im_dout;
                pc_q[wptr]   <= tag_pc;
            end
            rptr  <= bus.redirect ? '0 : rptr + PW'(pop);
            wptr  <= bus.redirect ? '0 : wptr + PW'(push);
            count <= bus.redirect ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed checks of fetch timing, stall, redirect, wrap and async reset
module tb_if_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    if_fetch_queue_if #(.IM_AW(10)) bus();
    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .IM_AW(10)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    always #5 clk = ~clk;
    // instruction memory contents are a function of the word address
    always @(posedge clk) if (bus.im_req) bus.im_dout <= 32'hC0DE0000 | 32'(bus.im_addr);
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset(input logic ready);
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = ready;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask
    task automatic redir(input logic [31:0] pc);
        bus.redirect = 1'b1;
        bus.redirect_pc = pc;
        #1;
    endtask
    initial begin
        logic [31:0] first_addr;
        bit seen;
        int reqs;
        bus.im_dout = '0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_im_req", 32'(bus.im_req), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_pc", bus.out_pc, 0);
        check("rst_inst", bus.out_inst, 0);
        // streaming from reset
        do_reset(1'b1);
        check("t1_req", 32'(bus.im_req), 1);
        check("t1_addr", 32'(bus.im_addr), 32'h0);
        step();
        check("t1_c2_valid", 32'(bus.out_valid), 0);
        check("t1_c2_addr", 32'(bus.im_addr), 32'h4);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_valid", 32'(bus.out_valid), 1);
            check("t1_pc", bus.out_pc, 32'(4 * k));
            check("t1_inst", bus.out_inst, 32'hC0DE0000 | 32'(4 * k));
        end
        check("t1_pc4", bus.out_pc4, 32'h10);
        // back-pressure fills the queue then stalls
        do_reset(1'b0);
        reqs = 0;
        for (int i = 1; i <= 10; i++) begin
            check("t2_req", 32'(bus.im_req), 32'(i <= 4));
            if (bus.im_req) begin
                reqs++;
                check("t2_addr", 32'(bus.im_addr), 32'(4 * (i - 1)));
            end
            if (i < 10) step();
        end
        check("t2_reqs", 32'(reqs), 4);
        check("t2_head_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        #1;
        seen = 0;
        first_addr = '0;
        for (int k = 0; k < 4; k++) begin
            if (bus.im_req && !seen) begin seen = 1; first_addr = 32'(bus.im_addr); end
            check("t2_drain_valid", 32'(bus.out_valid), 1);
            check("t2_drain_pc", bus.out_pc, 32'(4 * k));
            step();
        end
        for (int k = 0; k < 10 && !seen; k++) begin
            if (bus.im_req) begin seen = 1; first_addr = 32'(bus.im_addr); end
            else step();
        end
        check("t2_resume_seen", 32'(seen), 1);
        check("t2_resume_addr", first_addr, 32'h10);
        // redirect while streaming, unaligned target
        do_reset(1'b1);
        repeat (5) step();
        redir(32'h43);
        check("t3_req", 32'(bus.im_req), 1);
        check("t3_addr", 32'(bus.im_addr), 32'h40);
        step();
        bus.redirect = 1'b0;
        #1;
        check("t3_bubble", 32'(bus.out_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_valid", 32'(bus.out_valid), 1);
            check("t3_pc", bus.out_pc, 32'h40 + 32'(4 * k));
            check("t3_inst", bus.out_inst, 32'hC0DE0040 + 32'(4 * k));
        end
        // full queue, pop and redirect in the same cycle
        do_reset(1'b0);
        repeat (7) step();
        check("t4_full_req", 32'(bus.im_req), 0);
        bus.out_ready = 1'b1;
        redir(32'h200);
        check("t4_valid_r", 32'(bus.out_valid), 1);
        check("t4_addr", 32'(bus.im_addr), 32'h200);
        step();
        bus.redirect = 1'b0;
        #1;
        check("t4_empty", 32'(bus.out_valid), 0);
        step();
        check("t4_valid", 32'(bus.out_valid), 1);
        check("t4_pc", bus.out_pc, 32'h200);
        // wrap at top of the 32-bit space
        redir(32'hFFFFFFFC);
        check("t5_addr", 32'(bus.im_addr), 32'h3FC);
        step();
        bus.redirect = 1'b0;
        step();
        check("t5_pc", bus.out_pc, 32'hFFFFFFFC);
        check("t5_pc4", bus.out_pc4, 32'h0);
        check("t5_inst", bus.out_inst, 32'hC0DE03FC);
        step();
        check("t5_next_pc", bus.out_pc, 32'h0);
        check("t5_next_inst", bus.out_inst, 32'hC0DE0000);
        // back-to-back redirects: second wins
        redir(32'h100);
        step();
        redir(32'h180);
        step();
        bus.redirect = 1'b0;
        #1;
        check("t7_bubble", 32'(bus.out_valid), 0);
        step();
        check("t7_pc", bus.out_pc, 32'h180);
        step();
        check("t7_next_pc", bus.out_pc, 32'h184);
        // asynchronous reset in mid-cycle
        #2 rst = 1'b1;
        #1;
        check("t6_req", 32'(bus.im_req), 0);
        check("t6_valid", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t6_addr", 32'(bus.im_addr), 32'h0);
        step();
        step();
        check("t6_valid_after", 32'(bus.out_valid), 1);
        check("t6_pc", bus.out_pc, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
